decoder_scan_ctrl: RTL and testbench

//   Upstream sequencer for the 3-to-8 decoder: generates its enable and 3-bit

---
 rtl/decoder_scan_ctrl_if.sv | 24 ++
 rtl/decoder_scan_ctrl.sv | 150 +++++++++++++++
 tb/tb_decoder_scan_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/decoder_scan_ctrl_if.sv
// Handshake/bus bundle between a scan sequencer and its controller:
// sweep controls in, decoder enable/select and status pulses out.
interface decoder_scan_ctrl_if;
    logic       start;
    logic       cont;
    logic       stop;
    logic       hold;
    logic [7:0] skip_mask;
    logic       E_out;
    logic [2:0] Sel;
    logic       busy;
    logic       done;
    logic       wrap;

    modport master (
        output start, cont, stop, hold, skip_mask,
        input  E_out, Sel, busy, done, wrap
    );

    modport slave (
        input  start, cont, stop, hold, skip_mask,
        output E_out, Sel, busy, done, wrap
    );
endinterface

// File: rtl/decoder_scan_ctrl.sv
// Sequencer for a 3-to-8 decoder: walks the unmasked selects, each preceded by
// an enable-low blanking gap and held for a fixed dwell, one-shot or continuous.
module decoder_scan_ctrl #(
    parameter int DWELL_CYC = 4,
    parameter int BLANK_CYC = 1,
    parameter int CNT_W     = 8
) (
    input logic               clk,
    input logic               rst,
    decoder_scan_ctrl_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DWELL} state_t;

    localparam state_t           ENTRY      = (BLANK_CYC == 0) ? S_DWELL : S_BLANK;
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYC - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_mask;
    logic [2:0]       r_sel;
    logic             r_done;
    logic             r_wrap;
    logic             r_e_out;
    logic             r_busy;

    state_t           w_state;
    logic [CNT_W-1:0] w_cnt;
    logic [7:0]       w_mask;
    logic [2:0]       w_sel;
    logic             w_done;
    logic             w_wrap;
    logic             w_e_out;
    logic             w_busy;
    logic [3:0]       w_first;
    logic [3:0]       w_next;

    // Returns {found, index} of the lowest unmasked select at or above 'from'.
    function automatic logic [3:0] find_from(input logic [7:0] mask, input logic [3:0] from);
        logic [3:0] res;
        int unsigned idx;
        res = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            idx = 7 - k;
            if ((idx >= 32'(from)) && !mask[idx[2:0]])
                res = {1'b1, idx[2:0]};
        end
        return res;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_mask  <= '0;
            r_sel   <= '0;
            r_done  <= 1'b0;
            r_wrap  <= 1'b0;
            r_e_out <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_mask  <= w_mask;
            r_sel   <= w_sel;
            r_done  <= w_done;
            r_wrap  <= w_wrap;
            r_e_out <= w_e_out;
            r_busy  <= w_busy;
        end
    end

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_mask  = r_mask;
        w_sel   = r_sel;
        w_done  = 1'b0;
        w_wrap  = 1'b0;
        w_first = find_from(bus.skip_mask, 4'd0);
        w_next  = find_from(r_mask, {1'b0, r_sel} + 4'd1);

        if (bus.stop) begin
            w_state = S_IDLE;
            w_cnt   = '0;
        end else if (!bus.hold) begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        w_mask = bus.skip_mask;
                        w_cnt  = '0;
                        if (w_first[3]) begin
                            w_sel   = w_first[2:0];
                            w_state = ENTRY;
                        end else begin
                            w_done = 1'b1;
                        end
                    end
                end
                S_BLANK: begin
                    if (r_cnt == BLANK_LAST) begin
                        w_state = S_DWELL;
                        w_cnt   = '0;
                    end else begin
                        w_cnt = r_cnt + 1'b1;
                    end
                end
                S_DWELL: begin
                    if (r_cnt == DWELL_LAST) begin
                        w_cnt = '0;
                        if (w_next[3]) begin
                            w_sel   = w_next[2:0];
                            w_state = ENTRY;
                        end else if (bus.cont) begin
                            // Wrap re-samples the mask; an all-masked wrap ends the sweep.
                            w_mask = bus.skip_mask;
                            if (w_first[3]) begin
                                w_sel   = w_first[2:0];
                                w_state = ENTRY;
                                w_wrap  = 1'b1;
                            end else begin
                                w_state = S_IDLE;
                                w_done  = 1'b1;
                            end
                        end else begin
                            w_state = S_IDLE;
                            w_done  = 1'b1;
                        end
                    end else begin
                        w_cnt = r_cnt + 1'b1;
                    end
                end
                default: w_state = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_e_out = (w_state == S_DWELL);
        w_busy  = (w_state != S_IDLE);
    end

    assign bus.E_out = r_e_out;
    assign bus.Sel   = r_sel;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.wrap  = r_wrap;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Self-checking bench for decoder_scan_ctrl: slot-based reference model compared
// every cycle, directed sweeps with literal expectations, then random traffic.
module tb_decoder_scan_ctrl;
    localparam int DW = 4;
    localparam int BL = 1;
    localparam int L  = DW + BL;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decoder_scan_ctrl_if bus();

    decoder_scan_ctrl #(.DWELL_CYC(DW), .BLANK_CYC(BL), .CNT_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int vectors = 0;
    int errors  = 0;

    // Model: active flag, current select and position inside its BLANK+DWELL slot.
    bit         m_active;
    int         m_sel;
    int         m_pos;
    logic [7:0] m_mask;
    bit         m_done;
    bit         m_wrap;

    bit         chk_en = 1'b0;
    int         c_busy, c_done, c_wrap, c_e, mc_busy, mc_done;
    logic [7:0] seen;

    function automatic int lowest_from(input logic [7:0] mask, input int from);
        for (int i = from; i < 8; i++)
            if (!mask[i[2:0]]) return i;
        return -1;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int nx;
        if (rst) begin
            m_active = 0; m_sel = 0; m_pos = 0; m_mask = '0; m_done = 0; m_wrap = 0;
            return;
        end
        m_done = 0;
        m_wrap = 0;
        if (bus.stop) begin
            m_active = 0;
            m_pos    = 0;
        end else if (bus.hold) begin
            m_pos = m_pos;
        end else if (!m_active) begin
            if (bus.start) begin
                m_mask = bus.skip_mask;
                nx = lowest_from(m_mask, 0);
                if (nx < 0) m_done = 1;
                else begin m_active = 1; m_sel = nx; m_pos = 0; end
            end
        end else if (m_pos < L - 1) begin
            m_pos++;
        end else begin
            nx = lowest_from(m_mask, m_sel + 1);
            if (nx >= 0) begin
                m_sel = nx; m_pos = 0;
            end else if (bus.cont) begin
                m_mask = bus.skip_mask;
                nx = lowest_from(m_mask, 0);
                if (nx < 0) begin m_active = 0; m_done = 1; end
                else begin m_sel = nx; m_pos = 0; m_wrap = 1; end
            end else begin
                m_active = 0; m_done = 1;
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("E_out", 32'(bus.E_out), 32'(m_active && (m_pos >= BL)));
            cmp("Sel",   32'(bus.Sel),   32'(m_sel));
            cmp("busy",  32'(bus.busy),  32'(m_active));
            cmp("done",  32'(bus.done),  32'(m_done));
            cmp("wrap",  32'(bus.wrap),  32'(m_wrap));
            c_busy  += int'(bus.busy === 1'b1);
            c_done  += int'(bus.done === 1'b1);
            c_wrap  += int'(bus.wrap === 1'b1);
            c_e     += int'(bus.E_out === 1'b1);
            mc_busy += int'(m_active);
            mc_done += int'(m_done);
            if (bus.busy === 1'b1) seen[bus.Sel] = 1'b1;
        end
    end

    task automatic drive(input bit s, input bit c, input bit sp, input bit h, input logic [7:0] m);
        bus.start = s; bus.cont = c; bus.stop = sp; bus.hold = h; bus.skip_mask = m;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            #1;
        end
    endtask

    task automatic clr();
        c_busy = 0; c_done = 0; c_wrap = 0; c_e = 0; mc_busy = 0; mc_done = 0; seen = '0;
    endtask

    task automatic sweep_start(input bit c, input logic [7:0] m);
        drive(1, c, 0, 0, m);
        tick(1);
        drive(0, c, 0, 0, m);
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 8'h00);
        tick(1);
        chk_en = 1'b1;
        tick(1);
        cmp("rst_E_out", 32'(bus.E_out), 0);
        cmp("rst_Sel",   32'(bus.Sel),   0);
        cmp("rst_busy",  32'(bus.busy),  0);
        rst = 1'b0;
        tick(2);

        // Full one-shot sweep
        clr();
        sweep_start(0, 8'h00);
        tick(44);
        cmp("t1_busy", c_busy, 40);
        cmp("t1_done", c_done, 1);
        cmp("t1_eout", c_e, 32);
        cmp("t1_sels", 32'(seen), 32'hFF);
        cmp("t1_model_busy", mc_busy, 40);
        cmp("t1_model_done", mc_done, 1);

        // Alternate mask
        clr();
        sweep_start(0, 8'b1010_1010);
        tick(24);
        cmp("t2_busy", c_busy, 20);
        cmp("t2_done", c_done, 1);
        cmp("t2_sels", 32'(seen), 32'h55);

        // Continuous on select 7 only
        clr();
        sweep_start(1, 8'h7F);
        tick(29);
        cmp("t3_wrap", c_wrap, 5);
        cmp("t3_done", c_done, 0);
        cmp("t3_sels", 32'(seen), 32'h80);
        drive(0, 0, 1, 0, 8'h7F);
        tick(1);
        drive(0, 0, 0, 0, 8'h00);
        tick(2);

        // All masked
        clr();
        sweep_start(0, 8'hFF);
        cmp("t4_done_now", 32'(bus.done), 1);
        cmp("t4_busy_now", 32'(bus.busy), 0);
        tick(4);
        cmp("t4_busy", c_busy, 0);
        cmp("t4_done", c_done, 1);

        // Stop during select 3 dwell, then restart
        sweep_start(0, 8'h00);
        tick(16);
        cmp("t5_sel3", 32'(bus.Sel), 3);
        cmp("t5_dwell", 32'(bus.E_out), 1);
        clr();
        drive(0, 0, 1, 0, 8'h00);
        tick(1);
        cmp("t5_stop_e", 32'(bus.E_out), 0);
        cmp("t5_stop_busy", 32'(bus.busy), 0);
        cmp("t5_stop_done", 32'(bus.done), 0);
        drive(0, 0, 0, 0, 8'h00);
        sweep_start(0, 8'h00);
        cmp("t5_restart_sel", 32'(bus.Sel), 0);
        cmp("t5_restart_busy", 32'(bus.busy), 1);
        tick(42);

        // Hold three cycles mid-dwell
        clr();
        sweep_start(0, 8'h00);
        tick(2);
        drive(0, 0, 0, 1, 8'h00);
        tick(3);
        cmp("t6_hold_sel", 32'(bus.Sel), 0);
        cmp("t6_hold_e", 32'(bus.E_out), 1);
        drive(0, 0, 0, 0, 8'h00);
        tick(44);
        cmp("t6_busy", c_busy, 43);
        cmp("t6_done", c_done, 1);

        // Reset mid-sweep
        sweep_start(0, 8'h00);
        tick(7);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        cmp("t6_rst_e", 32'(bus.E_out), 0);
        cmp("t6_rst_sel", 32'(bus.Sel), 0);
        cmp("t6_rst_busy", 32'(bus.busy), 0);
        tick(2);

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            logic [7:0] m;
            case ($urandom_range(0, 7))
                0: m = 8'hFF;
                1: m = 8'h7F;
                2: m = 8'h00;
                default: m = 8'($urandom);
            endcase
            rst = ($urandom_range(0, 299) == 0);
            drive(($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 39) == 0) ? ~bus.cont : bus.cont,
                  ($urandom_range(0, 79) == 0),
                  ($urandom_range(0, 5) == 0),
                  m);
            tick(1);
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
